// File: rtl/reg_dump_streamer_pkg.sv
// Shared types and constants for the register-dump streamer: beat layout, FSM encoding,
// and the helper that builds a register beat.
package reg_dump_streamer_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned TAG_W    = ADDR_W + 1;
  localparam int unsigned CNT_W    = 16;

  localparam logic [TAG_W-1:0] TAG_PC = 6'h20;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StRegs
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  // Register beats carry their index as the tag; only the highest index closes a frame.
  function automatic beat_t reg_beat(logic [ADDR_W-1:0] idx, logic [DATA_W-1:0] data);
    beat_t b;
    b.tag  = {1'b0, idx};
    b.last = (idx == ADDR_W'(NUM_REGS - 1));
    b.data = data;
    return b;
  endfunction

endpackage

// File: rtl/reg_dump_streamer_if.sv
// Valid/ready beat stream between the dump streamer and its consumer.
interface reg_dump_streamer_if;
  import reg_dump_streamer_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_tag,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_tag,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/reg_dump_streamer.sv
// Snapshots the PC on request, then streams one beat per register read through a spare
// combinational RF port. Single output register, one beat per clock while ready is high.
module reg_dump_streamer
  import reg_dump_streamer_pkg::*;
#(
  parameter int unsigned FrameCntW = CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dump_req,
  input  logic [DATA_W-1:0]    pc_in,
  output logic [ADDR_W-1:0]    rf_raddr,
  input  logic [DATA_W-1:0]    rf_rdata,
  reg_dump_streamer_if.master  out,
  output logic                 busy,
  output logic                 dump_drop,
  output logic [FrameCntW-1:0] frame_cnt
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  beat_t                beat_q, beat_d;
  logic                 valid_q, valid_d;
  logic                 drop_q, drop_d;
  logic [FrameCntW-1:0] cnt_q, cnt_d;

  logic              accept;
  logic [ADDR_W-1:0] idx_next;

  assign accept   = valid_q & out.out_ready;
  assign idx_next = idx_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    drop_d  = dump_req && (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (dump_req) begin
          state_d     = StHdr;
          valid_d     = 1'b1;
          idx_d       = '0;
          beat_d.tag  = TAG_PC;
          beat_d.last = 1'b0;
          beat_d.data = pc_in;
        end
      end
      StHdr: begin
        if (accept) begin
          state_d = StRegs;
          idx_d   = '0;
          beat_d  = reg_beat('0, rf_rdata);
        end
      end
      StRegs: begin
        if (accept) begin
          if (beat_q.last) begin
            state_d = StIdle;
            valid_d = 1'b0;
            cnt_d   = cnt_q + FrameCntW'(1);
          end else begin
            idx_d  = idx_next;
            beat_d = reg_beat(idx_next, rf_rdata);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Address the register that the next accept will load.
  always_comb begin
    rf_raddr = '0;
    if (state_q == StRegs) begin
      rf_raddr = idx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out.out_valid = valid_q;
  assign out.out_data  = beat_q.data;
  assign out.out_tag   = beat_q.tag;
  assign out.out_last  = beat_q.last;
  assign busy          = (state_q != StIdle);
  assign dump_drop     = drop_q;
  assign frame_cnt     = cnt_q;

  a_last_tag: assert property (@(posedge clk) disable iff (!rst_n)
    beat_q.last |-> beat_q.tag == TAG_W'(NUM_REGS - 1));

  a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
    valid_q && !out.out_ready |=> valid_q && $stable(beat_q));

endmodule
